// File: rtl/compare_seq_if.sv
// Handshake and operand bundle for the sequential magnitude comparator.
// The master drives operands and start; the slave returns status and result flags.
interface compare_seq_if #(
    parameter int WIDTH = 64
);
    logic             start;
    logic             signed_mode;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             IGT;
    logic             ILE;
    logic             IEQ;
    logic             busy;
    logic             done;
    logic             FGT;
    logic             FLE;
    logic             FEQ;

    modport master (
        output start, signed_mode, A, B, IGT, ILE, IEQ,
        input  busy, done, FGT, FLE, FEQ
    );

    modport slave (
        input  start, signed_mode, A, B, IGT, ILE, IEQ,
        output busy, done, FGT, FLE, FEQ
    );
endinterface

// File: rtl/compare_seq.sv
// Multi-cycle magnitude comparator: walks CHUNK-bit slices from the most significant
// end and stops at the first slice that differs; full equality passes the cascade inputs.
module compare_seq #(
    parameter int WIDTH = 64,
    parameter int CHUNK = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    compare_seq_if.slave bus
);
    // WIDTH is expected to be a whole multiple of CHUNK.
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CHUNK-1:0] SIGN_BIT = CHUNK'(1) << (CHUNK - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_reg;
    logic [IDX_W-1:0] idx_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic             signed_reg;
    logic             igt_reg;
    logic             ile_reg;
    logic             ieq_reg;
    logic             busy_reg;
    logic             done_reg;
    logic             fgt_reg;
    logic             fle_reg;
    logic             feq_reg;

    logic [CHUNK-1:0] a_slice [NCHUNK];
    logic [CHUNK-1:0] b_slice [NCHUNK];
    logic [CHUNK-1:0] a_cur;
    logic [CHUNK-1:0] b_cur;
    logic             slice_gt;
    logic             slice_lt;

    // Flipping the sign bit of the top slice maps two's-complement order onto unsigned order.
    generate
        for (genvar gi = 0; gi < NCHUNK; gi++) begin : g_slice
            if (gi == NCHUNK - 1) begin : g_top
                assign a_slice[gi] = a_reg[gi*CHUNK +: CHUNK] ^ (signed_reg ? SIGN_BIT : '0);
                assign b_slice[gi] = b_reg[gi*CHUNK +: CHUNK] ^ (signed_reg ? SIGN_BIT : '0);
            end else begin : g_low
                assign a_slice[gi] = a_reg[gi*CHUNK +: CHUNK];
                assign b_slice[gi] = b_reg[gi*CHUNK +: CHUNK];
            end
        end
    endgenerate

    always_comb begin
        a_cur = '0;
        b_cur = '0;
        for (int i = 0; i < NCHUNK; i++) begin
            if (idx_reg == IDX_W'(i)) begin
                a_cur = a_slice[i];
                b_cur = b_slice[i];
            end
        end
    end

    assign slice_gt = (a_cur > b_cur);
    assign slice_lt = (a_cur < b_cur);

    // Operand and cascade latches are pure datapath and need no reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            idx_reg   <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            fgt_reg   <= 1'b0;
            fle_reg   <= 1'b0;
            feq_reg   <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (bus.start) begin
                        a_reg      <= bus.A;
                        b_reg      <= bus.B;
                        signed_reg <= bus.signed_mode;
                        igt_reg    <= bus.IGT;
                        ile_reg    <= bus.ILE;
                        ieq_reg    <= bus.IEQ;
                        idx_reg    <= IDX_W'(NCHUNK - 1);
                        busy_reg   <= 1'b1;
                        state_reg  <= RUN;
                    end
                end
                RUN: begin
                    if (slice_gt || slice_lt) begin
                        fgt_reg   <= slice_gt;
                        fle_reg   <= slice_lt;
                        feq_reg   <= 1'b0;
                        done_reg  <= 1'b1;
                        busy_reg  <= 1'b0;
                        state_reg <= IDLE;
                    end else if (idx_reg == '0) begin
                        fgt_reg   <= igt_reg;
                        fle_reg   <= ile_reg;
                        feq_reg   <= ieq_reg;
                        done_reg  <= 1'b1;
                        busy_reg  <= 1'b0;
                        state_reg <= IDLE;
                    end else begin
                        idx_reg <= idx_reg - 1'b1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy = busy_reg;
    assign bus.done = done_reg;
    assign bus.FGT  = fgt_reg;
    assign bus.FLE  = fle_reg;
    assign bus.FEQ  = feq_reg;
endmodule

// File: tb/tb_compare_seq.sv
// Scoreboard bench for compare_seq: three instances (64/16, 16/16, 32/8) checked
// against an arithmetic reference compare and a slice-walk latency model.
module tb_compare_seq;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    compare_seq_if #(.WIDTH(64)) bus64 ();
    compare_seq_if #(.WIDTH(16)) bus16 ();
    compare_seq_if #(.WIDTH(32)) bus32 ();

    compare_seq #(.WIDTH(64), .CHUNK(16)) dut64 (.clk(clk), .rst_n(rst_n), .bus(bus64));
    compare_seq #(.WIDTH(16), .CHUNK(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));
    compare_seq #(.WIDTH(32), .CHUNK(8))  dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32));

    int errors = 0;
    int checks = 0;

    typedef struct {
        int         id;
        logic [2:0] flags;
        int         lat;
    } exp_t;
    exp_t sb_q[$];

    function automatic int width_of(input int id);
        return (id == 0) ? 64 : (id == 1) ? 16 : 32;
    endfunction

    function automatic int chunk_of(input int id);
        return (id == 2) ? 8 : 16;
    endfunction

    function automatic logic [63:0] mask_of(input int w);
        return (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
    endfunction

    // Reference result: plain integer compare, sign-extending for signed mode.
    function automatic logic [2:0] ref_flags(input logic [63:0] a, input logic [63:0] b, input int w,
                                             input logic sm, input logic igt, input logic ile, input logic ieq);
        logic [63:0] ua, ub, ta, tb;
        longint      sa, sb;
        logic        gt, lt;
        ua = a & mask_of(w);
        ub = b & mask_of(w);
        ta = ua << (64 - w);
        tb = ub << (64 - w);
        sa = $signed(ta) >>> (64 - w);
        sb = $signed(tb) >>> (64 - w);
        gt = sm ? (sa > sb) : (ua > ub);
        lt = sm ? (sa < sb) : (ua < ub);
        if (!gt && !lt) return {igt, ile, ieq};
        return {gt, lt, 1'b0};
    endfunction

    // Latency = 1 + number of slices examined from the top until the first difference.
    function automatic int ref_lat(input logic [63:0] a, input logic [63:0] b, input int w, input int c);
        int          n;
        logic [63:0] cm, ua, ub;
        n  = w / c;
        cm = (64'd1 << c) - 64'd1;
        ua = a & mask_of(w);
        ub = b & mask_of(w);
        for (int k = 1; k <= n; k++) begin
            if (((ua >> ((n - k) * c)) & cm) != ((ub >> ((n - k) * c)) & cm)) return k + 1;
        end
        return n + 1;
    endfunction

    task automatic drive(input int id, input logic st, input logic [63:0] a, input logic [63:0] b,
                         input logic sm, input logic igt, input logic ile, input logic ieq);
        case (id)
            0: begin
                bus64.start = st; bus64.A = a; bus64.B = b; bus64.signed_mode = sm;
                bus64.IGT = igt; bus64.ILE = ile; bus64.IEQ = ieq;
            end
            1: begin
                bus16.start = st; bus16.A = a[15:0]; bus16.B = b[15:0]; bus16.signed_mode = sm;
                bus16.IGT = igt; bus16.ILE = ile; bus16.IEQ = ieq;
            end
            default: begin
                bus32.start = st; bus32.A = a[31:0]; bus32.B = b[31:0]; bus32.signed_mode = sm;
                bus32.IGT = igt; bus32.ILE = ile; bus32.IEQ = ieq;
            end
        endcase
    endtask

    task automatic set_start(input int id, input logic st);
        case (id)
            0:       bus64.start = st;
            1:       bus16.start = st;
            default: bus32.start = st;
        endcase
    endtask

    // {busy, done, FGT, FLE, FEQ}
    function automatic logic [4:0] outs(input int id);
        case (id)
            0:       return {bus64.busy, bus64.done, bus64.FGT, bus64.FLE, bus64.FEQ};
            1:       return {bus16.busy, bus16.done, bus16.FGT, bus16.FLE, bus16.FEQ};
            default: return {bus32.busy, bus32.done, bus32.FGT, bus32.FLE, bus32.FEQ};
        endcase
    endfunction

    // Called at a negedge (cycle 0); returns at the negedge of cycle 1 with start dropped.
    task automatic start_op(input int id, input logic [63:0] a, input logic [63:0] b,
                            input logic sm, input logic igt, input logic ile, input logic ieq);
        exp_t e;
        e.id    = id;
        e.flags = ref_flags(a, b, width_of(id), sm, igt, ile, ieq);
        e.lat   = ref_lat(a, b, width_of(id), chunk_of(id));
        sb_q.push_back(e);
        drive(id, 1'b1, a, b, sm, igt, ile, ieq);
        @(negedge clk);
        set_start(id, 1'b0);
    endtask

    // Entered at the cycle-1 negedge; leaves at the negedge of the done cycle (or after the bound).
    task automatic wait_done(input int id, output int lat, output bit proto_bad);
        logic [4:0] o;
        lat       = -1;
        proto_bad = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            o = outs(id);
            if (o[4] && o[3]) proto_bad = 1'b1;
            if (o[3]) begin
                lat = c;
                break;
            end
            if (!o[4]) proto_bad = 1'b1;
            @(negedge clk);
        end
    endtask

    task automatic do_op(input int id, input logic [63:0] a, input logic [63:0] b, input logic sm,
                         input logic igt, input logic ile, input logic ieq,
                         output logic [2:0] act_f, output int act_lat, output bit proto_bad, output exp_t e);
        logic [4:0] o;
        start_op(id, a, b, sm, igt, ile, ieq);
        wait_done(id, act_lat, proto_bad);
        o     = outs(id);
        act_f = o[2:0];
        e     = sb_q.pop_front();
        $display("op dut=%0d A=%h B=%h sm=%0d cas=%b%b%b flags=%b lat=%0d exp_flags=%b exp_lat=%0d",
                 id, a, b, sm, igt, ile, ieq, act_f, act_lat, e.flags, e.lat);
    endtask

    task automatic test_reset;
        logic [4:0] o;
        rst_n = 1'b0;
        for (int id = 0; id < 3; id++) drive(id, 1'b1, 64'd5, 64'd3, 1'b0, 1'b1, 1'b1, 1'b1);
        repeat (3) @(negedge clk);
        for (int id = 0; id < 3; id++) begin
            o = outs(id);
            checks++;
            if (o !== 5'b0) begin
                errors++;
                $display("FAIL reset_state dut=%0d: got %b want 00000", id, o);
            end
        end
        for (int id = 0; id < 3; id++) drive(id, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        $display("reset released");
    endtask

    task automatic test_top_slice;
        logic [2:0] f; int lat; bit bad; exp_t e;
        do_op(0, 64'hB000_0000_0000_0001, 64'h4000_0000_0000_0001, 1'b0, 1'b0, 1'b0, 1'b0, f, lat, bad, e);
        checks++; if (f !== e.flags) begin errors++; $display("FAIL top_flags: got %b want %b", f, e.flags); end
        checks++; if (lat !== e.lat) begin errors++; $display("FAIL top_latency: got %0d want %0d", lat, e.lat); end
        checks++; if (bad !== 1'b0) begin errors++; $display("FAIL top_busy_done: got %0d want 0", bad); end
    endtask

    task automatic test_bottom_slice;
        logic [2:0] f; int lat; bit bad; exp_t e;
        do_op(0, 64'h8C00_0000_0000_8C2E, 64'h8C00_0000_0000_8C2F, 1'b0, 1'b0, 1'b0, 1'b0, f, lat, bad, e);
        checks++; if (f !== e.flags) begin errors++; $display("FAIL bottom_flags: got %b want %b", f, e.flags); end
        checks++; if (lat !== e.lat) begin errors++; $display("FAIL bottom_latency: got %0d want %0d", lat, e.lat); end
        checks++; if (bad !== 1'b0) begin errors++; $display("FAIL bottom_busy_done: got %0d want 0", bad); end
    endtask

    task automatic test_equality;
        logic [2:0] cas [3] = '{3'b001, 3'b100, 3'b110};
        logic [2:0] f; int lat; bit bad; exp_t e;
        for (int i = 0; i < 3; i++) begin
            do_op(0, 64'h8C2F_8C2F_8C2F_8C2F, 64'h8C2F_8C2F_8C2F_8C2F, 1'b0, cas[i][2], cas[i][1], cas[i][0],
                  f, lat, bad, e);
            checks++; if (f !== e.flags) begin errors++; $display("FAIL equal_flags[%0d]: got %b want %b", i, f, e.flags); end
            checks++; if (lat !== e.lat) begin errors++; $display("FAIL equal_latency[%0d]: got %0d want %0d", i, lat, e.lat); end
            checks++; if (bad !== 1'b0) begin errors++; $display("FAIL equal_busy_done[%0d]: got %0d want 0", i, bad); end
        end
    endtask

    task automatic test_signed;
        logic [63:0] ta [3] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000};
        logic [63:0] tb [3] = '{64'h0000_0000_0000_0001, 64'h0000_0000_0000_0001, 64'h7FFF_FFFF_FFFF_FFFF};
        logic        ts [3] = '{1'b1, 1'b0, 1'b1};
        logic [2:0] f; int lat; bit bad; exp_t e;
        for (int i = 0; i < 3; i++) begin
            do_op(0, ta[i], tb[i], ts[i], 1'b0, 1'b0, 1'b0, f, lat, bad, e);
            checks++; if (f !== e.flags) begin errors++; $display("FAIL signed_flags[%0d]: got %b want %b", i, f, e.flags); end
            checks++; if (lat !== e.lat) begin errors++; $display("FAIL signed_latency[%0d]: got %0d want %0d", i, lat, e.lat); end
        end
    endtask

    task automatic test_restart_ignored;
        logic [4:0] o; logic [2:0] f; int ndone, first; exp_t e;
        start_op(0, 64'h8C00_0000_0000_8C2E, 64'h8C00_0000_0000_8C2F, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        drive(0, 1'b1, 64'hF000_0000_0000_0000, 64'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        set_start(0, 1'b0);
        ndone = 0; first = -1; f = 3'bxxx;
        for (int c = 3; c <= 14; c++) begin
            o = outs(0);
            if (o[3]) begin
                ndone++;
                if (first < 0) begin first = c; f = o[2:0]; end
            end
            @(negedge clk);
        end
        e = sb_q.pop_front();
        $display("op restart_ignored dones=%0d first=%0d flags=%b exp_flags=%b exp_lat=%0d", ndone, first, f, e.flags, e.lat);
        checks++; if (ndone !== 1) begin errors++; $display("FAIL restart_done_count: got %0d want 1", ndone); end
        checks++; if (first !== e.lat) begin errors++; $display("FAIL restart_latency: got %0d want %0d", first, e.lat); end
        checks++; if (f !== e.flags) begin errors++; $display("FAIL restart_flags: got %b want %b", f, e.flags); end
    endtask

    task automatic test_back_to_back;
        logic [4:0] o; logic [2:0] f1, f2; int lat1, lat2; bit bad1, bad2; exp_t e1, e2;
        start_op(0, 64'hB000_0000_0000_0001, 64'h4000_0000_0000_0001, 1'b0, 1'b0, 1'b0, 1'b0);
        wait_done(0, lat1, bad1);
        o = outs(0); f1 = o[2:0]; e1 = sb_q.pop_front();
        start_op(0, 64'd1, 64'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        o = outs(0);
        checks++; if (o[4:3] !== 2'b10) begin errors++; $display("FAIL b2b_busy_next: got busy,done=%b want 10", o[4:3]); end
        wait_done(0, lat2, bad2);
        o = outs(0); f2 = o[2:0]; e2 = sb_q.pop_front();
        $display("op back_to_back first=%b/%0d second=%b/%0d", f1, lat1, f2, lat2);
        checks++; if (f1 !== e1.flags || lat1 !== e1.lat) begin errors++; $display("FAIL b2b_first: got %b/%0d want %b/%0d", f1, lat1, e1.flags, e1.lat); end
        checks++; if (f2 !== e2.flags || lat2 !== e2.lat) begin errors++; $display("FAIL b2b_second: got %b/%0d want %b/%0d", f2, lat2, e2.flags, e2.lat); end
        checks++; if ((bad1 | bad2) !== 1'b0) begin errors++; $display("FAIL b2b_busy_done: got %0d want 0", bad1 | bad2); end
    endtask

    task automatic test_reset_mid;
        logic [4:0] o; int ndone;
        start_op(0, 64'h8C00_0000_0000_8C2E, 64'h8C00_0000_0000_8C2F, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        o = outs(0);
        checks++; if (o !== 5'b0) begin errors++; $display("FAIL midreset_clear: got %b want 00000", o); end
        rst_n = 1'b1;
        ndone = 0;
        for (int c = 0; c < 8; c++) begin
            o = outs(0);
            if (o[3]) ndone++;
            @(negedge clk);
        end
        void'(sb_q.pop_front());
        $display("op mid_reset dones_after=%0d", ndone);
        checks++; if (ndone !== 0) begin errors++; $display("FAIL midreset_no_done: got %0d want 0", ndone); end
    endtask

    task automatic test_sweep;
        logic [2:0] f; int lat; bit bad; exp_t e;
        logic [63:0] a, b;
        int k;
        for (int i = 0; i < 60; i++) begin
            int id;
            id = (i < 20) ? 1 : 2;
            a = {32'h0, $urandom};
            b = ($urandom_range(0, 3) == 0) ? a : {32'h0, $urandom};
            if (id == 2 && $urandom_range(0, 1) == 1) begin
                b = a;
                k = $urandom_range(0, 4);
                if (k < 4) b[k*8 +: 8] = 8'($urandom);
            end
            do_op(id, a, b, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), f, lat, bad, e);
            checks++; if (f !== e.flags) begin errors++; $display("FAIL sweep_flags[%0d]: got %b want %b", i, f, e.flags); end
            checks++; if (lat !== e.lat) begin errors++; $display("FAIL sweep_latency[%0d]: got %0d want %0d", i, lat, e.lat); end
            checks++; if (bad !== 1'b0) begin errors++; $display("FAIL sweep_busy_done[%0d]: got %0d want 0", i, bad); end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_top_slice();
        test_bottom_slice();
        test_equality();
        test_signed();
        test_restart_ignored();
        test_back_to_back();
        test_reset_mid();
        test_sweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/compare_seq.md
# compare_seq

Multi-cycle, parametrised magnitude comparator for wide operands. It is the successor to the 16-bit combinational cascade comparator. It compares A and B one CHUNK-bit slice per clock, starting at the most significant slice, and stops at the first slice that differs. It supports signed and unsigned modes and a start/busy/done handshake. The legacy IGT/ILE/IEQ cascade inputs are kept so the block can chain below a more significant comparator stage.

## Interface
- WIDTH, 64: operand width in bits. Must be an integer multiple of CHUNK.
- CHUNK, 16: bits compared per cycle. NCHUNK = WIDTH/CHUNK, and NCHUNK ≥ 1.
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  reset, synchronous and active-low.
- start  input  1  request a comparison. Sampled only in IDLE.
- signed_mode  input  1  1 = two's-complement compare, 0 = unsigned. Latched on start.
- A  input  WIDTH  operand A. Latched on start.
- B  input  WIDTH  operand B. Latched on start.
- IGT, ILE, IEQ  input  1 each  cascade result from the less significant side. Latched on start.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse; FGT/FLE/FEQ are new in that cycle.
- FGT, FLE, FEQ  output  1 each  A>B, A<B, A=B. Registered and held until the next result.

## Operation
- States: IDLE and RUN. An internal slice index idx runs from NCHUNK-1 down to 0, with width clog2(NCHUNK), minimum 1.
- IDLE with start=1:
  - latch A, B, signed_mode and the cascade inputs
  - set idx = NCHUNK-1
  - go to RUN
- IDLE with start=0: hold.
- RUN, each cycle: compare latched slice idx of A against slice idx of B, both unsigned.
- Signed mode: invert bit CHUNK-1 of both operands in the top slice (idx = NCHUNK-1) before comparing. This gives the signed order. Lower slices always compare unsigned.
- RUN, slice differs:
  - FGT = (a>b), FLE = (a<b), FEQ = 0
  - done = 1
  - go to IDLE
- RUN, slice equal and idx = 0:
  - FGT = IGT, FLE = ILE, FEQ = IEQ (latched cascade values passed through unmodified)
  - done = 1
  - go to IDLE
- RUN, slice equal and idx > 0: decrement idx and stay in RUN.
- start while in RUN is ignored and not queued. Input changes during RUN have no effect, because operands are latched.
- FGT/FLE/FEQ keep their previous values while busy. They update only on the edge that raises done.

## Timing
- Reset (rst_n low at a rising edge):
  - state = IDLE, idx = 0
  - busy = 0, done = 0, FGT = 0, FLE = 0, FEQ = 0
- Reset mid-operation aborts with no done pulse and clears the flags. It takes priority over start.
- Cycle numbering: start is sampled high at the end of cycle 0, so busy = 1 from cycle 1.
- If the decision comes at slice index NCHUNK-k (k slices examined), RUN occupies cycles 1..k.
- done, the new flags and busy = 0 appear in cycle k+1.
- Best-case latency is 2 cycles (top slice differs). Worst case is NCHUNK+1 (all equal, or only slice 0 differs).
- done is high for exactly one cycle. Because state is IDLE in the done cycle, a start in that cycle is accepted (back-to-back operation). That start sends busy high in the next cycle.
- NCHUNK = 1 degenerates to a fixed 2-cycle latency.
- done and busy are never high in the same cycle.
- Exactly one of FGT/FLE is set on an inequality. On full equality the flags equal the cascade inputs, including illegal combinations.

## Test plan
- Top slice decides. WIDTH=64, CHUNK=16, unsigned, A=0xB000_0000_0000_0001, B=0x4000_0000_0000_0001, start at cycle 0 -> busy in cycle 1 only; done=1, FGT=1, FLE=0, FEQ=0 in cycle 2.
- Bottom slice decides. A=0x8C00_0000_0000_8C2E, B=0x8C00_0000_0000_8C2F -> busy in cycles 1–4; done in cycle 5 with FLE=1.
- Full equality and cascade:
  - A=B=0x8C2F_8C2F_8C2F_8C2F with IGT=0, ILE=0, IEQ=1 -> FEQ=1 at cycle 5.
  - Rerun with IGT=1, IEQ=0 -> FGT=1.
- Signed mode. A=0xFFFF_FFFF_FFFF_FFFF, B=0x0000_0000_0000_0001:
  - signed_mode=1 -> FLE=1 at cycle 2
  - signed_mode=0 -> FGT=1 at cycle 2
  - A=0x8000_0000_0000_0000 vs B=0x7FFF_FFFF_FFFF_FFFF, signed -> FLE=1
- Handshake robustness:
  - Pulse start again in cycle 2 of a 5-cycle run -> ignored, exactly one done.
  - Start asserted in the done cycle -> second run accepted, busy next cycle.
  - rst_n=0 in cycle 2 -> busy, done and all flags 0 from cycle 3, and no done pulse.
- Parameter sweep. CHUNK=WIDTH=16 (NCHUNK=1) and WIDTH=32, CHUNK=8 -> latencies 2 and 2..5 respectively. Randomised operands must match a reference compare for both modes.
